// File: rtl/rx_stream_mux_pkg.sv
// Shared definitions for the RX stream multiplexer: policy and state
// encodings plus width helpers used by the top and the arbiter.
package rx_stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    PULL,
    LOAD,
    SHIFT
  } state_t;

  function automatic int nbytes(input int sample_w, input int byte_w);
    return sample_w / byte_w;
  endfunction

  // Index width for n items, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after the last-granted channel, searching upward with wrap-around.
module rr_arbiter
  import rx_stream_mux_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]              i_req,
  input  logic [idx_width(NUM_CH)-1:0]   i_last,
  output logic [NUM_CH-1:0]              o_grant,
  output logic                           o_valid
);

  localparam int IW = idx_width(NUM_CH);

  always_comb begin
    int unsigned k;
    k       = 0;
    o_grant = '0;
    o_valid = 1'b0;
    // Offset 1..NUM_CH so the last-granted channel is considered last.
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      k = (32'(i_last) + off) % NUM_CH;
      if (!o_valid && i_req[IW'(k)]) begin
        o_grant[IW'(k)] = 1'b1;
        o_valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_stream_mux.sv
// N-channel RX FIFO to byte-stream multiplexer: picks a channel (fixed or
// round-robin), pulls one sample and emits it MSB-first as tagged bytes.
module rx_stream_mux
  import rx_stream_mux_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 32,
  parameter int BYTE_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic                           i_sys_clk,
  input  logic                           i_reset,
  input  logic                           i_mode,
  input  logic [idx_width(NUM_CH)-1:0]   i_ch_sel,
  input  logic [NUM_CH-1:0]              i_ch_enable,
  output logic [NUM_CH-1:0]              o_fifo_pull,
  input  logic [NUM_CH*SAMPLE_W-1:0]     i_fifo_data,
  input  logic [NUM_CH-1:0]              i_fifo_empty,
  output logic [BYTE_W-1:0]              o_byte,
  output logic                           o_byte_valid,
  input  logic                           i_byte_ready,
  output logic [idx_width(NUM_CH)-1:0]   o_ch_id,
  output logic                           o_first_byte,
  output logic [CNT_W-1:0]               o_sample_cnt
);

  localparam int CH_W   = idx_width(NUM_CH);
  localparam int NBYTES = nbytes(SAMPLE_W, BYTE_W);
  localparam int BI_W   = idx_width(NBYTES);

  state_t              state;
  logic [CH_W-1:0]     cur_ch;
  logic [CH_W-1:0]     last_ch;
  logic [SAMPLE_W-1:0] shreg;
  logic [BI_W-1:0]     byte_idx;

  logic [NUM_CH-1:0]   rr_req;
  logic [NUM_CH-1:0]   rr_grant;
  logic                rr_valid;
  logic                cand_valid;
  logic [CH_W-1:0]     cand_ch;
  logic [NUM_CH-1:0]   cand_oh;
  logic [SAMPLE_W-1:0] fifo_words [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_words
    assign fifo_words[g] = i_fifo_data[g*SAMPLE_W +: SAMPLE_W];
  end

  assign rr_req = i_ch_enable & ~i_fifo_empty;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req   (rr_req),
    .i_last  (last_ch),
    .o_grant (rr_grant),
    .o_valid (rr_valid)
  );

  always_comb begin
    cand_valid = 1'b0;
    cand_ch    = '0;
    cand_oh    = '0;
    if (NUM_CH == 1) begin
      cand_valid = !i_fifo_empty[0];
      cand_oh[0] = cand_valid;
    end else if (i_mode == MODE_RR) begin
      cand_valid = rr_valid;
      cand_oh    = rr_grant;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (rr_grant[CH_W'(k)]) cand_ch = CH_W'(k);
      end
    end else if (32'(i_ch_sel) < NUM_CH) begin
      cand_valid          = !i_fifo_empty[i_ch_sel];
      cand_oh[i_ch_sel]   = cand_valid;
      cand_ch             = i_ch_sel;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      o_fifo_pull  <= '0;
      o_byte_valid <= 1'b0;
      o_byte       <= '0;
      o_first_byte <= 1'b0;
      o_ch_id      <= '0;
      o_sample_cnt <= '0;
      last_ch      <= CH_W'(NUM_CH - 1);
      cur_ch       <= '0;
      shreg        <= '0;
      byte_idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_valid) begin
            cur_ch      <= cand_ch;
            o_fifo_pull <= cand_oh;
            state       <= PULL;
          end
        end
        PULL: begin
          o_fifo_pull <= '0;
          state       <= LOAD;
        end
        // The MSB byte is presented straight from the FIFO word; shreg keeps the rest.
        LOAD: begin
          o_byte       <= fifo_words[cur_ch][SAMPLE_W-1 -: BYTE_W];
          shreg        <= fifo_words[cur_ch] << BYTE_W;
          byte_idx     <= '0;
          o_byte_valid <= 1'b1;
          o_first_byte <= 1'b1;
          o_ch_id      <= cur_ch;
          state        <= SHIFT;
        end
        SHIFT: begin
          if (i_byte_ready) begin
            if (byte_idx == BI_W'(NBYTES - 1)) begin
              o_byte_valid <= 1'b0;
              o_first_byte <= 1'b0;
              o_sample_cnt <= o_sample_cnt + CNT_W'(1);
              last_ch      <= cur_ch;
              state        <= IDLE;
            end else begin
              o_byte       <= shreg[SAMPLE_W-1 -: BYTE_W];
              shreg        <= shreg << BYTE_W;
              byte_idx     <= byte_idx + BI_W'(1);
              o_first_byte <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_stream_mux.sv
// Directed bench for rx_stream_mux (2 channels, 32-bit samples, 4-bit counter)
// with a queue-based FIFO model and hand-computed byte sequences.
module tb_rx_stream_mux;
  import rx_stream_mux_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_mode;
  logic [0:0]  i_ch_sel;
  logic [1:0]  i_ch_enable;
  logic [1:0]  o_fifo_pull;
  logic [63:0] i_fifo_data;
  logic [1:0]  i_fifo_empty;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic [0:0]  o_ch_id;
  logic        o_first_byte;
  logic [3:0]  o_sample_cnt;

  int          total = 0;
  int          bad = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          byte_log[$];
  int          ch_log[$];
  int          first_log[$];
  int          pulls0, pulls1;
  int          cycles;
  logic        prev_stall;
  logic [7:0]  prev_byte;
  logic [0:0]  prev_ch;
  int          exp_b[12] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                             8'h33, 8'h33, 8'h33, 8'h33};
  int          exp_c[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  always #5 clk = ~clk;

  rx_stream_mux #(.NUM_CH(2), .SAMPLE_W(32), .BYTE_W(8), .CNT_W(4)) dut (
    .i_sys_clk    (clk),
    .i_reset      (i_reset),
    .i_mode       (i_mode),
    .i_ch_sel     (i_ch_sel),
    .i_ch_enable  (i_ch_enable),
    .o_fifo_pull  (o_fifo_pull),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_ch_id      (o_ch_id),
    .o_first_byte (o_first_byte),
    .o_sample_cnt (o_sample_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, log transfers, serve FIFO pulls.
  task automatic cyc(input logic rdy);
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_valid", 32'(o_byte_valid), 32'd1);
      chk("stall_byte", 32'(o_byte), 32'(prev_byte));
      chk("stall_ch", 32'(o_ch_id), 32'(prev_ch));
    end
    i_byte_ready = rdy;
    if (o_byte_valid && rdy) begin
      byte_log.push_back(int'(o_byte));
      ch_log.push_back(int'(o_ch_id));
      first_log.push_back(int'(o_first_byte));
    end
    prev_stall = o_byte_valid && !rdy;
    prev_byte  = o_byte;
    prev_ch    = o_ch_id;
    if (o_fifo_pull != 2'b00) chk("pull_onehot", 32'($countones(o_fifo_pull)), 32'd1);
    if (o_fifo_pull[0]) begin
      pulls0++;
      chk("pull0_avail", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) i_fifo_data[31:0] = q0.pop_front();
    end
    if (o_fifo_pull[1]) begin
      pulls1++;
      chk("pull1_avail", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) i_fifo_data[63:32] = q1.pop_front();
    end
    i_fifo_empty = {q1.size() == 0, q0.size() == 0};
  endtask

  task automatic run_until(input int n, input int budget, input logic [3:0] pat,
                           output int used);
    int i;
    i = 0;
    while (byte_log.size() < n && i < budget) begin
      cyc(pat[i[1:0]]);
      i++;
    end
    used = i;
    chk("bytes_by_deadline", 32'(byte_log.size()), 32'(n));
  endtask

  task automatic clear_logs();
    byte_log.delete();
    ch_log.delete();
    first_log.delete();
    pulls0 = 0;
    pulls1 = 0;
  endtask

  task automatic do_reset();
    i_reset    = 1'b1;
    prev_stall = 1'b0;
    cyc(1'b0);
    i_reset    = 1'b0;
  endtask

  initial begin
    i_reset      = 1'b1;
    i_mode       = MODE_FIXED;
    i_ch_sel     = 1'b0;
    i_ch_enable  = 2'b11;
    i_byte_ready = 1'b0;
    i_fifo_data  = '0;
    i_fifo_empty = 2'b11;
    prev_stall   = 1'b0;
    clear_logs();
    repeat (3) cyc(1'b0);
    chk("rst_valid", 32'(o_byte_valid), 32'd0);
    chk("rst_pull", 32'(o_fifo_pull), 32'd0);
    chk("rst_byte", 32'(o_byte), 32'd0);
    chk("rst_first", 32'(o_first_byte), 32'd0);
    chk("rst_ch", 32'(o_ch_id), 32'd0);
    chk("rst_cnt", 32'(o_sample_cnt), 32'd0);
    i_reset = 1'b0;

    // Fixed mode, channel 0, one sample.
    q0.push_back(32'hA1B2C3D4);
    clear_logs();
    run_until(4, 40, 4'hF, cycles);
    repeat (3) cyc(1'b1);
    chk("fix_pull0", 32'(pulls0), 32'd1);
    chk("fix_pull1", 32'(pulls1), 32'd0);
    chk("fix_b0", 32'(byte_log[0]), 32'hA1);
    chk("fix_b1", 32'(byte_log[1]), 32'hB2);
    chk("fix_b2", 32'(byte_log[2]), 32'hC3);
    chk("fix_b3", 32'(byte_log[3]), 32'hD4);
    chk("fix_first", 32'({first_log[0][0], first_log[1][0], first_log[2][0], first_log[3][0]}), 32'b1000);
    chk("fix_ch", 32'(ch_log[0] + ch_log[1] + ch_log[2] + ch_log[3]), 32'd0);
    chk("fix_cnt", 32'(o_sample_cnt), 32'd1);

    // Round-robin from reset: ch0, ch1, ch0.
    do_reset();
    i_mode = MODE_RR;
    q0.push_back(32'h11111111);
    q0.push_back(32'h33333333);
    q1.push_back(32'h22222222);
    clear_logs();
    run_until(12, 80, 4'hF, cycles);
    repeat (3) cyc(1'b1);
    for (int j = 0; j < 12; j++) begin
      chk("rr_byte", 32'(byte_log[j]), 32'(exp_b[j]));
      chk("rr_ch", 32'(ch_log[j]), 32'(exp_c[j]));
      chk("rr_first", 32'(first_log[j]), 32'((j % 4) == 0));
    end
    chk("rr_pull0", 32'(pulls0), 32'd2);
    chk("rr_pull1", 32'(pulls1), 32'd1);
    chk("rr_cnt", 32'(o_sample_cnt), 32'd3);

    // Backpressure with ready pattern 1,0,0,1 on channel 1.
    i_mode   = MODE_FIXED;
    i_ch_sel = 1'b1;
    q1.push_back(32'hCAFEF00D);
    clear_logs();
    run_until(4, 60, 4'b1001, cycles);
    repeat (3) cyc(1'b1);
    chk("bp_count", 32'(byte_log.size()), 32'd4);
    chk("bp_b0", 32'(byte_log[0]), 32'hCA);
    chk("bp_b1", 32'(byte_log[1]), 32'hFE);
    chk("bp_b2", 32'(byte_log[2]), 32'hF0);
    chk("bp_b3", 32'(byte_log[3]), 32'h0D);
    chk("bp_ch", 32'(ch_log[0] + ch_log[3]), 32'd2);
    chk("bp_cnt", 32'(o_sample_cnt), 32'd4);

    // Round-robin with channel 1 enabled but empty.
    i_mode = MODE_RR;
    q0.push_back(32'h01020304);
    q0.push_back(32'h05060708);
    clear_logs();
    run_until(8, 60, 4'hF, cycles);
    repeat (3) cyc(1'b1);
    chk("emp_pull1", 32'(pulls1), 32'd0);
    chk("emp_pull0", 32'(pulls0), 32'd2);
    for (int j = 0; j < 8; j++) begin
      chk("emp_byte", 32'(byte_log[j]), 32'(j + 1));
      chk("emp_ch", 32'(ch_log[j]), 32'd0);
    end
    chk("emp_cnt", 32'(o_sample_cnt), 32'd6);

    // Reset after the second byte of DEADBEEF; the next word starts clean.
    i_mode   = MODE_FIXED;
    i_ch_sel = 1'b0;
    q0.push_back(32'hDEADBEEF);
    q0.push_back(32'h0BADF00D);
    clear_logs();
    run_until(2, 40, 4'hF, cycles);
    cyc(1'b0);
    i_reset    = 1'b1;
    prev_stall = 1'b0;
    cyc(1'b0);
    chk("mid_rst_valid", 32'(o_byte_valid), 32'd0);
    chk("mid_rst_cnt", 32'(o_sample_cnt), 32'd0);
    chk("mid_rst_pulls", 32'(pulls0), 32'd1);
    i_reset = 1'b0;
    clear_logs();
    run_until(4, 40, 4'hF, cycles);
    repeat (3) cyc(1'b1);
    chk("post_rst_first", 32'(first_log[0]), 32'd1);
    chk("post_rst_b0", 32'(byte_log[0]), 32'h0B);
    chk("post_rst_b1", 32'(byte_log[1]), 32'hAD);
    chk("post_rst_b2", 32'(byte_log[2]), 32'hF0);
    chk("post_rst_b3", 32'(byte_log[3]), 32'h0D);
    chk("post_rst_cnt", 32'(o_sample_cnt), 32'd1);

    // 17 back-to-back samples: counter wraps to 1, 7 cycles per sample.
    do_reset();
    for (int j = 0; j < 17; j++) q0.push_back(32'h10203040 + 32'(j));
    clear_logs();
    run_until(68, 300, 4'hF, cycles);
    chk("wrap_cycles", 32'(cycles), 32'd119);
    repeat (3) cyc(1'b1);
    chk("wrap_cnt", 32'(o_sample_cnt), 32'd1);
    chk("wrap_pulls", 32'(pulls0), 32'd17);
    chk("wrap_last_b0", 32'(byte_log[64]), 32'h10);
    chk("wrap_last_b3", 32'(byte_log[67]), 32'h50);
    chk("wrap_last_first", 32'(first_log[64]), 32'd1);

    // Disabling ch0 mid-sample lets the sample finish, then stops selection.
    i_mode      = MODE_RR;
    i_ch_enable = 2'b01;
    q0.push_back(32'h55AA55AA);
    clear_logs();
    run_until(1, 40, 4'hF, cycles);
    i_ch_enable = 2'b00;
    run_until(4, 40, 4'hF, cycles);
    repeat (3) cyc(1'b1);
    chk("dis_b0", 32'(byte_log[0]), 32'h55);
    chk("dis_b1", 32'(byte_log[1]), 32'hAA);
    chk("dis_b2", 32'(byte_log[2]), 32'h55);
    chk("dis_b3", 32'(byte_log[3]), 32'hAA);
    chk("dis_cnt", 32'(o_sample_cnt), 32'd2);
    q0.push_back(32'h77777777);
    repeat (10) cyc(1'b1);
    chk("dis_no_pull", 32'(pulls0), 32'd1);
    chk("dis_no_bytes", 32'(byte_log.size()), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_stream_mux.md
# rx_stream_mux

Parametrised N-channel receive-stream multiplexer between the per-channel RX sample FIFOs (0.9 GHz, 2.4 GHz, and later channels) and the 8-bit SMI data path. Selects a channel by fixed or round-robin policy, pulls one complete sample from that channel's FIFO, and serialises it MSB-first into bytes. Each byte carries its channel ID and a sample-start flag. Replaces the single-channel hard-wired FIFO-to-SMI connection and runs entirely in the system clock domain, which is the FIFO read side.

## Interface
Parameters:
- NUM_CH, 2: number of RX channels (1..8)
- SAMPLE_W, 32: FIFO sample width in bits; must be a multiple of BYTE_W
- BYTE_W, 8: output byte width
- CNT_W, 16: width of the per-sample counter

Ports:
- i_sys_clk  in  1  system clock; the only clock
- i_reset  in  1  synchronous, active-high reset
- i_mode  in  1  selection policy: 0 = fixed channel i_ch_sel, 1 = round-robin over i_ch_enable
- i_ch_sel  in  $clog2(NUM_CH) (min 1)  channel used in fixed mode
- i_ch_enable  in  NUM_CH  per-channel enable for round-robin mode
- o_fifo_pull  out  NUM_CH  one-hot, one-cycle FIFO read enable
- i_fifo_data  in  NUM_CH*SAMPLE_W  FIFO read data; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W]; valid one cycle after pull
- i_fifo_empty  in  NUM_CH  FIFO empty flags
- o_byte  out  BYTE_W  output byte
- o_byte_valid  out  1  byte valid
- i_byte_ready  in  1  consumer ready
- o_ch_id  out  $clog2(NUM_CH) (min 1)  channel of the current byte
- o_first_byte  out  1  high on the first (MSB) byte of each sample
- o_sample_cnt  out  CNT_W  number of fully emitted samples; wraps

## Operation
- NBYTES = SAMPLE_W/BYTE_W. A transfer happens when o_byte_valid and i_byte_ready are both high in the same cycle.
- State machine states: IDLE, PULL, LOAD, SHIFT.
- IDLE: evaluate candidates every cycle.
  - Fixed mode: the candidate is i_ch_sel when !i_fifo_empty[i_ch_sel]. i_ch_enable is ignored.
  - Round-robin mode: the candidate is the first channel after last_ch (modulo NUM_CH, searching upward) with enable set and FIFO non-empty.
  - On a candidate: latch cur_ch, go to PULL. With no candidate, stay in IDLE.
- PULL: assert o_fifo_pull[cur_ch] for exactly one cycle, go to LOAD.
- LOAD: capture i_fifo_data slice of cur_ch into the shift register, set byte_idx=0, go to SHIFT.
- SHIFT: o_byte = shift register MSB byte; o_byte_valid=1; o_first_byte=(byte_idx==0); o_ch_id=cur_ch.
  - On each transfer: shift left by BYTE_W and increment byte_idx.
  - On the transfer of byte NBYTES-1: increment o_sample_cnt, set last_ch=cur_ch, go to IDLE.
- Outputs are held stable while o_byte_valid && !i_byte_ready.
- Changes to mode, sel or enable during PULL/LOAD/SHIFT affect only the next selection. A channel disabled mid-sample completes its current sample.
- Empty FIFO: never pull when i_fifo_empty of the selected channel is high. The pull decision uses the empty flag as sampled in IDLE.
- NUM_CH=1: round-robin degenerates to fixed channel 0.
- Only one o_fifo_pull bit is ever high.

## Timing
- Reset values:
  - State IDLE, o_fifo_pull=0, o_byte_valid=0, o_byte=0.
  - o_first_byte=0, o_ch_id=0, o_sample_cnt=0.
  - last_ch=NUM_CH-1, so channel 0 is served first in round-robin.
- Reset mid-operation discards any partial sample. The FIFO word already pulled is lost.
- Latency: candidate seen in IDLE at cycle t gives pull at t+1, capture at t+2, first byte valid at t+3.
- Throughput with i_byte_ready held high: NBYTES+3 cycles per sample; 7 cycles for 32/8.
- o_sample_cnt updates the cycle after the final byte transfer. It wraps from 2^CNT_W-1 to 0.
- All outputs are registered. No combinational path from i_byte_ready to o_byte or o_byte_valid.

## Structure
- A shared package holds:
  - mode encodings MODE_FIXED=0 and MODE_RR=1
  - state encodings
  - the NBYTES derivation
- Sub-module rr_arbiter: NUM_CH-wide request (enable & !empty), last-grant pointer in, one-hot grant plus valid out. It is purely combinational and is instantiated once.

## Test plan
- Fixed mode, ch0, FIFO holds 0xA1B2C3D4, ready always high:
  - pull pulses once
  - bytes A1,B2,C3,D4 with o_first_byte only on A1 and o_ch_id=0
  - o_sample_cnt=1
- Round-robin, both enabled, ch0 holds 0x11111111 and 0x33333333, ch1 holds 0x22222222:
  - sample order 11..,22..,33..
  - o_ch_id sequence 0,1,0
- Backpressure: ready toggled 1,0,0,1,... during a sample:
  - o_byte and o_ch_id stable while stalled
  - no byte duplicated or lost
  - exactly 4 transfers
- Empty handling: ch1 enabled but empty, ch0 non-empty, round-robin:
  - o_fifo_pull[1] never asserts
  - only ch0 samples emitted
- Reset asserted after the second byte of 0xDEADBEEF:
  - o_byte_valid=0 and o_sample_cnt=0 the next cycle
  - after reset the next FIFO word starts with o_first_byte=1
- CNT_W=4: emit 17 samples, then o_sample_cnt=1 (wrap). Disable ch0 mid-sample: the current sample still completes.
